mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multicycle sequencer for the MIPS datapath. Decodes the opcode latched in the instruction register and steps a Moore state machine through fetch, decode, execute, memory and write-back. Drives every datapath control line: PC/IR write enables, memory strobes, register-file write, ALU source muxes, ALU-op class and PC-source select. Sits beside the datapath; `ula_control` still refines `ula_operation` using funct.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low; state forced to FETCH while low
- `opcode`  in  6  instruction[31:26] from IR
- `mem_ready`  in  1  memory handshake; 1 = read data valid / write accepted this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero flag (datapath ANDs it)
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALU out
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  IR load
- `mem_to_reg`  out  1  write-back select: 1 = MDR, 0 = ALU out
- `reg_dst`  out  1  1 = rd, 0 = rt
- `reg_write`  out  1  register-file write enable
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `ula_operation`  out  2  00 = add, 01 = sub, 10 = by funct
- `pc_source`  out  2  00 = ALU result, 01 = ALU out reg, 10 = jump target
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction
- `illegal_op`  out  1  sticky flag: an unsupported opcode was decoded
- `state`  out  4  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ula_operation=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, ula_operation=00 (branch-target precompute).
  - Next state by opcode: 000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP (see Configuration).
  - Any other opcode -> FETCH, sets illegal_op, pulses instr_done.
- MEMADR: alu_src_a=1, alu_src_b=10, ula_operation=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1; instr_done=mem_ready; then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, ula_operation=10. Next: ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ula_operation=00. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ula_operation=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- Any output not listed for a state is 0. Undefined state encodings (12–15) -> FETCH.
- illegal_op is cleared only by reset.

## Timing
- State register updates on the rising edge of `clock`. Outputs are combinational from `state`, `opcode` and `mem_ready` (Moore, plus mem_ready gating).
- While reset=0: state=FETCH, illegal_op=0, and pc_write, ir_write, reg_write, mem_write, mem_read, pc_write_cond and instr_done are all forced 0. Every other output is 0.
- Reset deassertion takes effect on the next rising edge. Reset mid-instruction aborts it; no partial write-back follows.
- Latency in cycles with mem_ready=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes hold steady while stalled.
- opcode is sampled in DECODE and later states. The IR is stable after FETCH, so no internal copy is kept.

## Configuration
- `MIPS_JUMP_EN` defined: opcode 000010 -> JUMP state, as above.
- Undefined: the JUMP state is not compiled. Opcode 000010 is treated as illegal (-> FETCH, illegal_op set), and pc_source never drives 10.

## Test plan
- Reset: hold reset=0 for 3 cycles -> state=0, all strobes 0, illegal_op=0. Release with mem_ready=1 -> pc_write=ir_write=1 in the first cycle.
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4. reg_write=1, mem_to_reg=1 in cycle 5. instr_done pulses once.
- sw with mem_ready low for 2 cycles in MEMWR -> MEMWR held 3 cycles, mem_write=1 throughout, instr_done only in the final cycle. Total 6 cycles.
- R-type then beq -> EXEC shows ula_operation=10. BRANCH shows ula_operation=01, pc_write_cond=1, pc_source=01. Cycle counts 4 and 3.
- Opcode 111111 -> DECODE -> FETCH, illegal_op=1 stays set. Opcode 000010 gives the same result with `MIPS_JUMP_EN` undefined. With it defined, the JUMP state drives pc_write=1, pc_source=10.
- Reset pulled low during MEMRD -> immediate state=0 and strobes 0. No reg_write ever occurs for the aborted lw.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the MIPS multicycle sequencer (master) and the datapath (slave).
interface mips_multicycle_control_if;
  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  logic [OP_W-1:0] opcode;
  logic            mem_ready;
  logic            pc_write;
  logic            pc_write_cond;
  logic            i_or_d;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            mem_to_reg;
  logic            reg_dst;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      ula_operation;
  logic [1:0]      pc_source;
  logic            instr_done;
  logic            illegal_op;
  logic [ST_W-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ula_operation,
           pc_source, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ula_operation,
           pc_source, instr_done, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath: fetch/decode/execute/mem/write-back.
// Optional MIPS_JUMP_EN compiles in the JUMP state for opcode 000010.
module mips_multicycle_control (
  input logic                        clock,
  input logic                        reset,
  mips_multicycle_control_if.master  bus
);
  localparam int unsigned ST_W = 4;
  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_JUMP_EN
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`endif

  typedef enum logic [ST_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
`ifdef MIPS_JUMP_EN
    JUMP   = 4'd9,
`endif
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q;
  logic   illegal_set;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       ir_write_c, mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
  logic       instr_done_c;
  logic [1:0] alu_src_b_c, ula_operation_c, pc_source_c;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Sticky unsupported-opcode flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          illegal_q <= 1'b0;
    else if (illegal_set) illegal_q <= 1'b1;
  end

  // Next state and per-state control decode.
  always_comb begin
    state_d         = FETCH;
    illegal_set     = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    instr_done_c    = 1'b0;
    alu_src_b_c     = 2'b00;
    ula_operation_c = 2'b00;
    pc_source_c     = 2'b00;

    case (state_q)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        state_d     = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_c = 2'b11;
        case (bus.opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MIPS_JUMP_EN
          OP_J:         state_d = JUMP;
`endif
          default: begin
            illegal_set  = 1'b1;
            instr_done_c = 1'b1;
            state_d      = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        state_d    = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        instr_done_c = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        mem_write_c  = 1'b1;
        i_or_d_c     = 1'b1;
        instr_done_c = bus.mem_ready;
        state_d      = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a_c     = 1'b1;
        ula_operation_c = 2'b10;
        state_d         = ALUWB;
      end
      ALUWB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = 1'b1;
        instr_done_c = 1'b1;
        state_d      = FETCH;
      end
      ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        alu_src_a_c     = 1'b1;
        ula_operation_c = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        instr_done_c    = 1'b1;
        state_d         = FETCH;
      end
`ifdef MIPS_JUMP_EN
      JUMP: begin
        pc_write_c   = 1'b1;
        pc_source_c  = 2'b10;
        instr_done_c = 1'b1;
        state_d      = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // While reset is low the state register already reads FETCH; the gate
  // keeps FETCH's strobes from leaking out before release.
  assign bus.pc_write      = reset & pc_write_c;
  assign bus.pc_write_cond = reset & pc_write_cond_c;
  assign bus.i_or_d        = reset & i_or_d_c;
  assign bus.mem_read      = reset & mem_read_c;
  assign bus.mem_write     = reset & mem_write_c;
  assign bus.ir_write      = reset & ir_write_c;
  assign bus.mem_to_reg    = reset & mem_to_reg_c;
  assign bus.reg_dst       = reset & reg_dst_c;
  assign bus.reg_write     = reset & reg_write_c;
  assign bus.alu_src_a     = reset & alu_src_a_c;
  assign bus.instr_done    = reset & instr_done_c;
  assign bus.alu_src_b     = {2{reset}} & alu_src_b_c;
  assign bus.ula_operation = {2{reset}} & ula_operation_c;
  assign bus.pc_source     = {2{reset}} & pc_source_c;
  assign bus.illegal_op    = illegal_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle scoreboard plus latency checks.
module tb_mips_multicycle_control;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_operation;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;
  } ctl_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mips_multicycle_control_if bus ();
  mips_multicycle_control dut (.clock(clock), .reset(reset), .bus(bus));

  ctl_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] m_state = 4'd0;
  logic       m_illegal = 1'b0;
  logic       last_done = 1'b0;
  logic       saw_rw = 1'b0;
  string      tag = "reset";

  function automatic logic legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000: return 1'b1;
`ifdef MIPS_JUMP_EN
      6'b000010: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_next(input logic [3:0] s, input logic [5:0] op, input logic rdy);
    case (s)
      4'd0: return rdy ? 4'd1 : 4'd0;
      4'd1: case (op)
              6'b000000:            return 4'd6;
              6'b100011, 6'b101011: return 4'd2;
              6'b000100:            return 4'd8;
              6'b001000:            return 4'd10;
`ifdef MIPS_JUMP_EN
              6'b000010:            return 4'd9;
`endif
              default:              return 4'd0;
            endcase
      4'd2: return (op == 6'b100011) ? 4'd3 : 4'd5;
      4'd3: return rdy ? 4'd4 : 4'd3;
      4'd5: return rdy ? 4'd0 : 4'd5;
      4'd6: return 4'd7;
      4'd10: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic ctl_t model_out(input logic [3:0] s, input logic [5:0] op,
                                     input logic rdy, input logic rst, input logic ill);
    ctl_t o;
    o = '0;
    if (!rst) return o;
    o.state = s;
    o.illegal_op = ill;
    case (s)
      4'd0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      4'd1: begin o.alu_src_b = 2'b11; o.instr_done = !legal(op); end
      4'd2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd3: begin o.mem_read = 1; o.i_or_d = 1; end
      4'd4: begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      4'd5: begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = rdy; end
      4'd6: begin o.alu_src_a = 1; o.ula_operation = 2'b10; end
      4'd7: begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
      4'd8: begin o.alu_src_a = 1; o.ula_operation = 2'b01; o.pc_write_cond = 1;
                  o.pc_source = 2'b01; o.instr_done = 1; end
      4'd9: begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
      4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd11: begin o.reg_write = 1; o.instr_done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input logic rdy);
    ctl_t g, e;
    bus.mem_ready = rdy;
    #1;
    sb.push_back(model_out(m_state, bus.opcode, rdy, reset, m_illegal));
    @(negedge clock);
    g = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
         bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
         bus.alu_src_b, bus.ula_operation, bus.pc_source, bus.instr_done,
         bus.illegal_op, bus.state};
    e = sb.pop_front();
    vectors++;
    assert (g === e) else begin
      miscompares++;
      $error("FAIL %s cycle: observed %h expected %h", tag, g, e);
    end
    last_done = g.instr_done;
    if (g.reg_write === 1'b1) saw_rw = 1'b1;
    @(posedge clock);
    if (!reset) begin
      m_state = 4'd0;
      m_illegal = 1'b0;
    end else begin
      if (m_state == 4'd1 && !legal(bus.opcode)) m_illegal = 1'b1;
      m_state = m_next(m_state, bus.opcode, rdy);
    end
    #1;
  endtask

  // Run one instruction, stalling `stalls` cycles in state `stall_st`; check latency.
  task automatic run(input string name, input logic [5:0] op, input logic [3:0] stall_st,
                     input int stalls, input int exp_cycles);
    int cycles;
    int left;
    tag = name;
    bus.opcode = op;
    cycles = 0;
    left = stalls;
    last_done = 1'b0;
    while (!last_done && cycles < 20) begin
      if (m_state == stall_st && left > 0) begin
        left--;
        step(1'b0);
      end else begin
        step(1'b1);
      end
      cycles++;
    end
    vectors++;
    assert (cycles === exp_cycles) else begin
      miscompares++;
      $error("FAIL %s latency: observed %0d expected %0d", name, cycles, exp_cycles);
    end
  endtask

  initial begin
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b1;
    @(posedge clock);
    #1;
    tag = "reset";
    repeat (3) step(1'b1);
    reset = 1'b1;
    tag = "release";
    // First FETCH after release: pc_write and ir_write follow mem_ready.
    step(1'b0);
    step(1'b0);

    run("lw",     6'b100011, 4'd15, 0, 5);
    run("sw",     6'b101011, 4'd5,  2, 6);
    run("rtype",  6'b000000, 4'd15, 0, 4);
    run("beq",    6'b000100, 4'd15, 0, 3);
    run("addi",   6'b001000, 4'd15, 0, 4);
    run("lw_fst", 6'b100011, 4'd0,  2, 7);
    run("lw_rst", 6'b100011, 4'd3,  1, 6);
    run("ill",    6'b111111, 4'd15, 0, 2);
    vectors++;
    assert (bus.illegal_op === 1'b1) else begin
      miscompares++;
      $error("FAIL illegal_sticky: observed %b expected 1", bus.illegal_op);
    end
    run("rtype2", 6'b000000, 4'd15, 0, 4);
`ifdef MIPS_JUMP_EN
    run("jump",   6'b000010, 4'd15, 0, 3);
`else
    run("j_ill",  6'b000010, 4'd15, 0, 2);
`endif

    // Abort a lw while stalled in MEMRD; no write-back may follow.
    tag = "abort";
    bus.opcode = 6'b100011;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    saw_rw = 1'b0;
    reset = 1'b0;
    step(1'b1);
    step(1'b1);
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    vectors++;
    assert (saw_rw === 1'b0) else begin
      miscompares++;
      $error("FAIL abort_no_write: observed reg_write %b expected 0", saw_rw);
    end
    vectors++;
    assert (bus.illegal_op === 1'b0) else begin
      miscompares++;
      $error("FAIL abort_illegal_clr: observed %b expected 0", bus.illegal_op);
    end
    run("lw_post", 6'b100011, 4'd15, 0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
